exe_stage: RTL

Execute stage of the 5-stage LoongArch pipeline, directly downstream of the decode stage. Latches the 116-bit decode-to-execute bus under a valid/allowin handshake and evaluates the 12-op one-hot ALU. It issues the data-SRAM request for `ld.w`/`st.w`, forwards the result to decode for bypass and load-use stall, and hands the instruction to the memory stage.

---
 rtl/exe_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage
// Purpose  : Execute stage of the 5-stage LoongArch pipeline. Latches the
//            decode-to-execute bus under a valid/allowin handshake, evaluates
//            the one-hot 12-op ALU, issues the data-SRAM request for ld.w and
//            st.w, forwards the write-back info to decode (bypass/load-use) and
//            hands the instruction on to the memory stage.
// Ports    : clk, reset (sync, active-high)
//            ds2es_valid / es_allowin / ds2es_bus[115:0] / ds_pc[31:0]
//                                                  - from decode
//            ms_allowin / es2ms_valid / es2ms_bus[70:0] - to memory stage
//            es_rf_zip[38:0]                       - bypass info to decode
//            data_sram_en/we[3:0]/addr[31:0]/wdata[31:0] - data SRAM request
// Revision : 1.0  initial release
// ============================================================================
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ds2es_valid,
    output logic         es_allowin,
    input  logic [115:0] ds2es_bus,
    input  logic [31:0]  ds_pc,
    input  logic         ms_allowin,
    output logic         es2ms_valid,
    output logic [70:0]  es2ms_bus,
    output logic [38:0]  es_rf_zip,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);

    // Single-cycle ALU: the stage never needs extra cycles of its own.
    localparam logic c_es_ready_go = 1'b1;

    logic        r_es_valid;
    logic [11:0] r_alu_op;
    logic        r_res_from_mem;
    logic [31:0] r_alu_src1;
    logic [31:0] r_alu_src2;
    logic        r_mem_we;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rkd_value;
    logic [31:0] r_es_pc;

    logic        w_es_allowin;
    logic        w_load_en;
    logic        w_rf_we;
    logic [4:0]  w_shamt;
    logic [31:0] w_add_res;
    logic [31:0] w_sub_res;
    logic [31:0] w_slt_res;
    logic [31:0] w_sltu_res;
    logic [31:0] w_sra_res;
    logic [31:0] w_alu_result;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_es_allowin = ~r_es_valid | (c_es_ready_go & ms_allowin);
    assign w_load_en    = ds2es_valid & w_es_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_es_valid     <= 1'b0;
            r_alu_op       <= 12'd0;
            r_res_from_mem <= 1'b0;
            r_alu_src1     <= 32'd0;
            r_alu_src2     <= 32'd0;
            r_mem_we       <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= 5'd0;
            r_rkd_value    <= 32'd0;
            r_es_pc        <= 32'd0;
        end else begin
            if (w_es_allowin) begin
                r_es_valid <= ds2es_valid;
            end
            // Stale payload is left in place when the stage empties; every
            // side effect downstream is qualified by r_es_valid.
            if (w_load_en) begin
                r_alu_op       <= ds2es_bus[115:104];
                r_res_from_mem <= ds2es_bus[103];
                r_alu_src1     <= ds2es_bus[102:71];
                r_alu_src2     <= ds2es_bus[70:39];
                r_mem_we       <= ds2es_bus[38];
                r_rf_we        <= ds2es_bus[37];
                r_rf_waddr     <= ds2es_bus[36:32];
                r_rkd_value    <= ds2es_bus[31:0];
                r_es_pc        <= ds_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    assign w_shamt    = r_alu_src2[4:0];
    assign w_add_res  = r_alu_src1 + r_alu_src2;
    assign w_sub_res  = r_alu_src1 - r_alu_src2;
    assign w_slt_res  = {31'd0, ($signed(r_alu_src1) < $signed(r_alu_src2))};
    assign w_sltu_res = {31'd0, (r_alu_src1 < r_alu_src2)};
    assign w_sra_res  = $signed(r_alu_src1) >>> w_shamt;

    // AND-OR mux over the one-hot op: an all-zero op falls out as zero.
    assign w_alu_result = ({32{r_alu_op[0]}}  & w_add_res)
                        | ({32{r_alu_op[1]}}  & w_sub_res)
                        | ({32{r_alu_op[2]}}  & w_slt_res)
                        | ({32{r_alu_op[3]}}  & w_sltu_res)
                        | ({32{r_alu_op[4]}}  & (r_alu_src1 & r_alu_src2))
                        | ({32{r_alu_op[5]}}  & ~(r_alu_src1 | r_alu_src2))
                        | ({32{r_alu_op[6]}}  & (r_alu_src1 | r_alu_src2))
                        | ({32{r_alu_op[7]}}  & (r_alu_src1 ^ r_alu_src2))
                        | ({32{r_alu_op[8]}}  & (r_alu_src1 << w_shamt))
                        | ({32{r_alu_op[9]}}  & (r_alu_src1 >> w_shamt))
                        | ({32{r_alu_op[10]}} & w_sra_res)
                        | ({32{r_alu_op[11]}} & r_alu_src2);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_rf_we = r_rf_we & r_es_valid;

    assign es_allowin  = w_es_allowin;
    assign es2ms_valid = r_es_valid & c_es_ready_go;
    assign es2ms_bus   = {r_es_pc, r_res_from_mem, w_rf_we, r_rf_waddr, w_alu_result};
    assign es_rf_zip   = {r_res_from_mem, w_rf_we, r_rf_waddr, w_alu_result};

    // Requests are only issued on the cycle the memory stage takes the
    // instruction, so a held store is never written twice.
    assign data_sram_en    = r_es_valid & (r_res_from_mem | r_mem_we) & ms_allowin;
    assign data_sram_we    = {4{r_es_valid & r_mem_we & ms_allowin}};
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = r_rkd_value;

endmodule
`default_nettype wire
